cache_arbiter: RTL and testbench

- Two-master Wishbone pipelined arbiter that sits directly upstream of the cache front end (cache `inbus`).
- Typical masters: instruction fetch on m0, data load/store on m1.
- Grants one master at a time and holds the grant for that master's whole `cyc`.
- Tracks outstanding requests so that a master dropping `cyc` never leaves stray acks on the shared bus.

---
 rtl/cache_arbiter_if.sv | 26 ++
 rtl/cache_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Pipelined Wishbone bus bundle shared by the cache arbiter's masters and its
// downstream cache port.
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [AWIDTH-1:0] adr;
  logic [3:0]        sel;
  logic [DWIDTH-1:0] dat_o;
  logic [DWIDTH-1:0] dat_i;
  logic              ack;
  logic              stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, stall
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-master Wishbone pipelined arbiter in front of the cache. The grant is
// held for a master's whole cycle, and acks still owed to a master that has
// dropped cyc are absorbed in a drain state.
module cache_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int OCWIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  if_wb.slave                m0,
  if_wb.slave                m1,
  if_wb.master               outbus,
  output logic [1:0]         grant,
  output logic [OCWIDTH-1:0] outstanding
);

  typedef enum logic [1:0] {G_IDLE, G_M0, G_M1, G_DRAIN} state_t;

  localparam logic [OCWIDTH-1:0] COUNT_MAX = '1;
  localparam logic [OCWIDTH-1:0] COUNT_ONE = {{(OCWIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [OCWIDTH-1:0]   count_q, count_d;
  logic [1:0]           grant_q, grant_d;

  logic                 full;
  logic                 accept;
  logic                 retire;

  logic                 o_cyc, o_stb, o_we;
  logic [AWIDTH-1:0]    o_adr;
  logic [3:0]           o_sel;
  logic [DWIDTH-1:0]    o_dat;
  logic                 m0_ack, m0_stall, m1_ack, m1_stall;
  logic [DWIDTH-1:0]    m0_dat, m1_dat;

  assign full = (count_q == COUNT_MAX);

  // Bus routing: the owner sees the cache directly, everyone else is held off.
  // A full counter blocks new strobes so the count can never wrap.
  always_comb begin
    o_cyc    = 1'b0;
    o_stb    = 1'b0;
    o_we     = 1'b0;
    o_adr    = '0;
    o_sel    = '0;
    o_dat    = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m0_dat   = '0;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    m1_dat   = '0;
    unique case (state_q)
      G_M0: begin
        o_cyc    = m0.cyc;
        o_stb    = m0.stb & ~full;
        o_we     = m0.we;
        o_adr    = m0.adr;
        o_sel    = m0.sel;
        o_dat    = m0.dat_o;
        m0_ack   = outbus.ack;
        m0_stall = outbus.stall | full;
        m0_dat   = outbus.dat_i;
      end
      G_M1: begin
        o_cyc    = m1.cyc;
        o_stb    = m1.stb & ~full;
        o_we     = m1.we;
        o_adr    = m1.adr;
        o_sel    = m1.sel;
        o_dat    = m1.dat_o;
        m1_ack   = outbus.ack;
        m1_stall = outbus.stall | full;
        m1_dat   = outbus.dat_i;
      end
      G_DRAIN: begin
        o_cyc = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = o_cyc & o_stb & ~outbus.stall;
  assign retire = outbus.ack & (count_q != '0);

  // Next-state logic; a release only skips the drain when nothing is still owed.
  always_comb begin
    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + COUNT_ONE;
    end else if (!accept && retire) begin
      count_d = count_q - COUNT_ONE;
    end

    state_d = state_q;
    unique case (state_q)
      G_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? G_M0 : G_M1;
        end else if (m0.cyc) begin
          state_d = G_M0;
        end else if (m1.cyc) begin
          state_d = G_M1;
        end
      end
      G_M0: begin
        if (!m0.cyc) begin
          if (count_d == '0) begin
            state_d = m1.cyc ? G_M1 : G_IDLE;
          end else begin
            state_d = G_DRAIN;
          end
        end
      end
      G_M1: begin
        if (!m1.cyc) begin
          if (count_d == '0) begin
            state_d = m0.cyc ? G_M0 : G_IDLE;
          end else begin
            state_d = G_DRAIN;
          end
        end
      end
      G_DRAIN: begin
        if (count_d == '0) begin
          state_d = G_IDLE;
        end
      end
      default: state_d = G_IDLE;
    endcase

    last_d  = last_q;
    grant_d = 2'b00;
    if (state_d == G_M0) begin
      last_d  = 1'b0;
      grant_d = 2'b01;
    end else if (state_d == G_M1) begin
      last_d  = 1'b1;
      grant_d = 2'b10;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= G_IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      grant_q <= grant_d;
    end
  end

  assign outbus.cyc   = o_cyc;
  assign outbus.stb   = o_stb;
  assign outbus.we    = o_we;
  assign outbus.adr   = o_adr;
  assign outbus.sel   = o_sel;
  assign outbus.dat_o = o_dat;

  assign m0.ack   = m0_ack;
  assign m0.stall = m0_stall;
  assign m0.dat_i = m0_dat;
  assign m1.ack   = m1_ack;
  assign m1.stall = m1_stall;
  assign m1.dat_i = m1_dat;

  assign grant       = grant_q;
  assign outstanding = count_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a cycle-by-cycle vector table plus hand
// sequences for pipelining, counter saturation and asynchronous reset.
module tb_cache_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] grant;
  logic [1:0] outstanding;

  int n_checks = 0;
  int n_fails  = 0;

  if_wb #(.AWIDTH(32), .DWIDTH(32)) m0_bus ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) m1_bus ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) out_bus ();

  cache_arbiter #(.AWIDTH(32), .DWIDTH(32), .OCWIDTH(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0          (m0_bus.slave),
    .m1          (m1_bus.slave),
    .outbus      (out_bus.master),
    .grant       (grant),
    .outstanding (outstanding)
  );

  always #5 clk_i = ~clk_i;

  // stim = {c0,s0,c1,s1,cache_stall,cache_ack}; expo = {ocyc,ostb,a0,st0,a1,st1}
  typedef struct {
    string    name;
    bit       rst;
    bit [5:0] stim;
    bit [1:0] grant;
    bit [1:0] outst;
    bit [5:0] expo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(string name, bit rst, bit [5:0] stim,
                                  bit [1:0] g, bit [1:0] o, bit [5:0] expo);
    vec_t v;
    v.name  = name;
    v.rst   = rst;
    v.stim  = stim;
    v.grant = g;
    v.outst = o;
    v.expo  = expo;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 1'b1; m0_bus.sel = 4'hF;
    m0_bus.adr = 32'h100; m0_bus.dat_o = 32'hDEADBEEF;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 1'b0; m1_bus.sel = 4'hF;
    m1_bus.adr = 32'h200; m1_bus.dat_o = 32'h0;
    out_bus.ack = 0; out_bus.stall = 0; out_bus.dat_i = 32'h0;
  endtask

  // Leaves time at posedge+1 with the arbiter idle.
  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    m0_bus.cyc    = v.stim[5];
    m0_bus.stb    = v.stim[4];
    m1_bus.cyc    = v.stim[3];
    m1_bus.stb    = v.stim[2];
    out_bus.stall = v.stim[1];
    out_bus.ack   = v.stim[0];
    out_bus.dat_i = 32'hCAFE0000 + 32'(idx);
  endtask

  task automatic check_vector(vec_t v, int idx);
    checkOutput({v.name, ".grant"}, 32'(grant), 32'(v.grant));
    checkOutput({v.name, ".outst"}, 32'(outstanding), 32'(v.outst));
    checkOutput({v.name, ".ocyc"}, 32'(out_bus.cyc), 32'(v.expo[5]));
    checkOutput({v.name, ".ostb"}, 32'(out_bus.stb), 32'(v.expo[4]));
    checkOutput({v.name, ".m0ack"}, 32'(m0_bus.ack), 32'(v.expo[3]));
    checkOutput({v.name, ".m0stall"}, 32'(m0_bus.stall), 32'(v.expo[2]));
    checkOutput({v.name, ".m1ack"}, 32'(m1_bus.ack), 32'(v.expo[1]));
    checkOutput({v.name, ".m1stall"}, 32'(m1_bus.stall), 32'(v.expo[0]));
    if (v.expo[5] && v.expo[4]) begin
      checkOutput({v.name, ".adr"}, out_bus.adr, (v.grant == 2'b01) ? 32'h100 : 32'h200);
      checkOutput({v.name, ".we"}, 32'(out_bus.we), (v.grant == 2'b01) ? 32'd1 : 32'd0);
      checkOutput({v.name, ".dat"}, out_bus.dat_o, (v.grant == 2'b01) ? 32'hDEADBEEF : 32'h0);
    end
    if (v.expo[3]) checkOutput({v.name, ".m0dat"}, m0_bus.dat_i, 32'hCAFE0000 + 32'(idx));
    if (v.expo[1]) checkOutput({v.name, ".m1dat"}, m1_bus.dat_i, 32'hCAFE0000 + 32'(idx));
  endtask

  initial begin
    int accepted;
    int idx;
    int peak;
    logic [31:0] addrs [3];

    add_vec("a_idle",  1'b1, 6'b110000, 2'b00, 2'd0, 6'b000101);
    add_vec("a_req",   1'b0, 6'b110000, 2'b01, 2'd0, 6'b110001);
    add_vec("a_ack",   1'b0, 6'b100001, 2'b01, 2'd1, 6'b101001);
    add_vec("a_rel",   1'b0, 6'b000000, 2'b01, 2'd0, 6'b000001);
    add_vec("b_arb",   1'b1, 6'b111100, 2'b00, 2'd0, 6'b000101);
    add_vec("b_m0",    1'b0, 6'b111100, 2'b01, 2'd0, 6'b110001);
    add_vec("b_ack",   1'b0, 6'b101101, 2'b01, 2'd1, 6'b101001);
    add_vec("b_hand",  1'b0, 6'b001100, 2'b01, 2'd0, 6'b000001);
    add_vec("b_m1",    1'b0, 6'b001100, 2'b10, 2'd0, 6'b110100);
    add_vec("b_m1ack", 1'b0, 6'b001001, 2'b10, 2'd1, 6'b100110);
    add_vec("d_hand",  1'b0, 6'b110000, 2'b10, 2'd0, 6'b000100);
    add_vec("d_req1",  1'b0, 6'b110000, 2'b01, 2'd0, 6'b110001);
    add_vec("d_req2",  1'b0, 6'b110000, 2'b01, 2'd1, 6'b110001);
    add_vec("d_drop",  1'b0, 6'b001100, 2'b01, 2'd2, 6'b000001);
    add_vec("d_dr1",   1'b0, 6'b001101, 2'b00, 2'd2, 6'b100101);
    add_vec("d_dr2",   1'b0, 6'b001101, 2'b00, 2'd1, 6'b100101);
    add_vec("d_idle",  1'b0, 6'b001100, 2'b00, 2'd0, 6'b000101);
    add_vec("d_m1",    1'b0, 6'b001100, 2'b10, 2'd0, 6'b110100);
    add_vec("d_rel1",  1'b0, 6'b000001, 2'b10, 2'd1, 6'b000110);
    add_vec("v_ack0",  1'b0, 6'b000001, 2'b00, 2'd0, 6'b000101);
    add_vec("r_both",  1'b0, 6'b101000, 2'b00, 2'd0, 6'b000101);
    add_vec("r_m0",    1'b0, 6'b101000, 2'b01, 2'd0, 6'b100001);
    add_vec("r_rel",   1'b0, 6'b001000, 2'b01, 2'd0, 6'b000001);
    add_vec("r_m1",    1'b0, 6'b001000, 2'b10, 2'd0, 6'b100100);
    add_vec("r_rel1",  1'b0, 6'b100000, 2'b10, 2'd0, 6'b000100);
    add_vec("r_m0b",   1'b0, 6'b100000, 2'b01, 2'd0, 6'b100001);

    clear_inputs();
    rst_i = 1'b1;
    #12 rst_i = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      applyStimulus(vecs[i], i);
      #2;
      check_vector(vecs[i], i);
      next_cycle();
    end

    // Three pipelined m1 reads behind a two-cycle cache stall; m0 waits throughout.
    do_reset();
    addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h208;
    idx  = 0;
    peak = 0;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = addrs[0];
    next_cycle();
    m0_bus.cyc = 1;
    for (int k = 0; k < 8; k++) begin
      m1_bus.stb    = (idx < 3);
      m1_bus.adr    = (idx < 3) ? addrs[idx] : 32'h0;
      out_bus.stall = (k < 2);
      out_bus.ack   = (k >= 5);
      out_bus.dat_i = 32'hA0000000 + 32'(k);
      #2;
      if (32'(outstanding) > peak) peak = 32'(outstanding);
      checkOutput("pipe.m0stall", 32'(m0_bus.stall), 32'd1);
      checkOutput("pipe.m0ack", 32'(m0_bus.ack), 32'd0);
      if (k >= 2 && idx < 3) begin
        checkOutput("pipe.m1stall", 32'(m1_bus.stall), 32'd0);
        checkOutput("pipe.adr", out_bus.adr, addrs[idx]);
      end
      if (k >= 5) begin
        checkOutput("pipe.m1ack", 32'(m1_bus.ack), 32'd1);
        checkOutput("pipe.m1dat", m1_bus.dat_i, 32'hA0000000 + 32'(k));
      end
      if (m1_bus.stb && !m1_bus.stall) idx++;
      next_cycle();
    end
    checkOutput("pipe.accepted", 32'(idx), 32'd3);
    checkOutput("pipe.peak", 32'(peak), 32'd3);
    checkOutput("pipe.final_outst", 32'(outstanding), 32'd0);

    // Saturation: the cache never acks and m0 keeps strobing.
    do_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    next_cycle();
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      #2;
      if (m0_bus.stb && !m0_bus.stall) accepted++;
      if (k >= 3) begin
        checkOutput("sat.m0stall", 32'(m0_bus.stall), 32'd1);
        checkOutput("sat.ostb", 32'(out_bus.stb), 32'd0);
      end
      next_cycle();
    end
    checkOutput("sat.accepted", 32'(accepted), 32'd3);
    checkOutput("sat.outst", 32'(outstanding), 32'd3);

    // Asynchronous reset while m1 owns the bus with two requests in flight.
    do_reset();
    m1_bus.cyc = 1; m1_bus.stb = 1;
    next_cycle();
    next_cycle();
    next_cycle();
    m1_bus.stb = 0;
    #1;
    checkOutput("arst.pre_outst", 32'(outstanding), 32'd2);
    checkOutput("arst.pre_grant", 32'(grant), 32'd2);
    rst_i = 1'b1;
    #1;
    checkOutput("arst.grant", 32'(grant), 32'd0);
    checkOutput("arst.outst", 32'(outstanding), 32'd0);
    checkOutput("arst.ocyc", 32'(out_bus.cyc), 32'd0);
    checkOutput("arst.ostb", 32'(out_bus.stb), 32'd0);
    checkOutput("arst.adr", out_bus.adr, 32'd0);
    checkOutput("arst.m1stall", 32'(m1_bus.stall), 32'd1);
    m1_bus.cyc = 0;
    next_cycle();
    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_bus.ack = 1;
      #2;
      checkOutput("arst.stray_m1ack", 32'(m1_bus.ack), 32'd0);
      next_cycle();
    end
    out_bus.ack = 0;
    checkOutput("arst.post_outst", 32'(outstanding), 32'd0);
    checkOutput("arst.post_grant", 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
